// File: rtl/segre_pkg.sv
// Shared types and constants for the segre dcache refill path.
// Build option SEGRE_DCACHE_PLRU_EN selects tree pseudo-LRU replacement (round-robin otherwise).
package segre_pkg;

  localparam int unsigned DCACHE_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    FILL     = 2'd3
  } dcache_refill_state_t;

endpackage

// File: rtl/segre_dcache_victim_sel.sv
// Victim lane selection: lowest invalid lane, else the replacement-policy lane.
// SEGRE_DCACHE_PLRU_EN defined: tree pseudo-LRU; undefined: round-robin pointer.
module segre_dcache_victim_sel
  import segre_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned INDEX_SIZE = $clog2(NUM_LANES)
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic [NUM_LANES-1:0]  lane_valid_i,
  input  logic                  invalidate_i,
  input  logic                  hit_i,
  input  logic [INDEX_SIZE-1:0] hit_index_i,
  input  logic                  fill_i,
  input  logic [INDEX_SIZE-1:0] fill_index_i,
  input  logic                  fill_policy_i,
  output logic [INDEX_SIZE-1:0] victim_index_c,
  output logic                  victim_policy_c
);

  logic [INDEX_SIZE-1:0] w_free_idx;
  logic                  w_any_free;
  logic [INDEX_SIZE-1:0] w_policy_idx;

  // Scan downwards so the lowest-numbered free lane wins.
  always_comb begin
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (!1'(lane_valid_i >> i)) begin
        w_free_idx = INDEX_SIZE'(i);
        w_any_free = 1'b1;
      end
    end
  end

`ifdef SEGRE_DCACHE_PLRU_EN
  localparam int unsigned TREE_W = NUM_LANES - 1;

  logic [TREE_W-1:0] r_tree;
  logic              w_unused;

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit=1 steers toward the right child.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] tree,
                                                   input logic [INDEX_SIZE-1:0] lane);
    logic [TREE_W-1:0] t;
    int                node;
    logic              dir;
    t = tree;
    for (int lvl = 0; lvl < int'(INDEX_SIZE); lvl++) begin
      node = (1 << lvl) - 1 + int'(lane >> (int'(INDEX_SIZE) - lvl));
      dir  = 1'(lane >> (int'(INDEX_SIZE) - 1 - lvl));
      t    = (t & ~(TREE_W'(1) << node)) | (TREE_W'(~dir) << node);
    end
    return t;
  endfunction

  always_comb begin
    w_policy_idx = '0;
    for (int lvl = 0; lvl < int'(INDEX_SIZE); lvl++) begin
      w_policy_idx = (w_policy_idx << 1) |
                     INDEX_SIZE'(1'(r_tree >> ((1 << lvl) - 1 + int'(w_policy_idx))));
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_tree <= '0;
    end else if (invalidate_i) begin
      r_tree <= '0;
    end else if (fill_i) begin
      r_tree <= plru_touch(r_tree, fill_index_i);
    end else if (hit_i) begin
      r_tree <= plru_touch(r_tree, hit_index_i);
    end
  end

  assign w_unused = fill_policy_i;
`else
  logic [INDEX_SIZE-1:0] r_ptr;
  logic                  w_unused;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_ptr <= '0;
    end else if (invalidate_i) begin
      r_ptr <= '0;
    end else if (fill_i && fill_policy_i) begin
      r_ptr <= r_ptr + INDEX_SIZE'(1);
    end
  end

  assign w_policy_idx = r_ptr;
  assign w_unused     = ^{hit_i, hit_index_i};
`endif

  assign victim_index_c  = w_any_free ? w_free_idx : w_policy_idx;
  assign victim_policy_c = ~w_any_free;

endmodule

// File: rtl/segre_dcache_refill_ctrl.sv
// Dcache miss refill controller: victim pick, memory line fetch, one-cycle fill to tag/data arrays.
// SEGRE_DCACHE_PLRU_EN (in the victim selector) switches replacement from round-robin to tree PLRU.
module segre_dcache_refill_ctrl
  import segre_pkg::*;
#(
  parameter  int unsigned ADDR_SIZE  = 32,
  parameter  int unsigned TAG_SIZE   = 28,
  parameter  int unsigned NUM_LANES  = 8,
  parameter  int unsigned LINE_W     = DCACHE_LINE_W,
  localparam int unsigned INDEX_SIZE = $clog2(NUM_LANES)
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  miss_i,
  input  logic [TAG_SIZE-1:0]   miss_tag_i,
  input  logic                  hit_i,
  input  logic [INDEX_SIZE-1:0] hit_index_i,
  input  logic [NUM_LANES-1:0]  lane_valid_i,
  input  logic                  invalidate_i,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic [ADDR_SIZE-1:0]  mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [LINE_W-1:0]     mem_rdata_i,
  output logic                  fill_o,
  output logic [INDEX_SIZE-1:0] fill_index_o,
  output logic [TAG_SIZE-1:0]   fill_tag_o,
  output logic [LINE_W-1:0]     fill_data_o
);

  localparam int unsigned OFF_SIZE = ADDR_SIZE - TAG_SIZE;

  dcache_refill_state_t  r_state, w_state_next;
  logic                  r_drop, w_drop_next;
  logic                  w_capture, w_load;
  logic [TAG_SIZE-1:0]   r_tag;
  logic [INDEX_SIZE-1:0] r_victim;
  logic                  r_victim_policy;
  logic [INDEX_SIZE-1:0] w_victim;
  logic                  w_victim_policy;
  logic                  r_busy, r_mem_req, r_fill, r_fill_policy;
  logic [INDEX_SIZE-1:0] r_fill_index;
  logic [TAG_SIZE-1:0]   r_fill_tag;
  logic [LINE_W-1:0]     r_fill_data;

  segre_dcache_victim_sel #(
    .NUM_LANES  (NUM_LANES),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_victim_sel (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .lane_valid_i    (lane_valid_i),
    .invalidate_i    (invalidate_i),
    .hit_i           (hit_i),
    .hit_index_i     (hit_index_i),
    .fill_i          (r_fill),
    .fill_index_i    (r_fill_index),
    .fill_policy_i   (r_fill_policy),
    .victim_index_c  (w_victim),
    .victim_policy_c (w_victim_policy)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
    end
  end

  // Invalidate before gnt cancels outright; once granted, the returning line must be drained.
  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        w_drop_next = 1'b0;
        if (miss_i && !invalidate_i) begin
          w_capture    = 1'b1;
          w_state_next = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_gnt_i) begin
          w_state_next = MEM_WAIT;
          w_drop_next  = invalidate_i;
        end else if (invalidate_i) begin
          w_state_next = IDLE;
        end
      end
      MEM_WAIT: begin
        if (invalidate_i) begin
          w_drop_next = 1'b1;
        end
        if (mem_rvalid_i) begin
          if (r_drop || invalidate_i) begin
            w_state_next = IDLE;
          end else begin
            w_load       = 1'b1;
            w_state_next = FILL;
          end
        end
      end
      FILL: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_busy          <= 1'b0;
      r_mem_req       <= 1'b0;
      r_fill          <= 1'b0;
      r_tag           <= '0;
      r_victim        <= '0;
      r_victim_policy <= 1'b0;
      r_fill_index    <= '0;
      r_fill_tag      <= '0;
      r_fill_data     <= '0;
      r_fill_policy   <= 1'b0;
    end else begin
      r_busy    <= (w_state_next != IDLE);
      r_mem_req <= (w_state_next == MEM_REQ);
      r_fill    <= (w_state_next == FILL);
      if (w_capture) begin
        r_tag           <= miss_tag_i;
        r_victim        <= w_victim;
        r_victim_policy <= w_victim_policy;
      end
      if (w_load) begin
        r_fill_index  <= r_victim;
        r_fill_tag    <= r_tag;
        r_fill_data   <= mem_rdata_i;
        r_fill_policy <= r_victim_policy;
      end
    end
  end

  assign busy_o       = r_busy;
  assign mem_req_o    = r_mem_req;
  assign mem_addr_o   = {r_tag, OFF_SIZE'(0)};
  assign fill_o       = r_fill;
  assign fill_index_o = r_fill_index;
  assign fill_tag_o   = r_fill_tag;
  assign fill_data_o  = r_fill_data;

endmodule

// File: tb/tb_segre_dcache_refill_ctrl.sv
// Bench for segre_dcache_refill_ctrl: directed scenarios plus random transactions vs a transaction model.
module tb_segre_dcache_refill_ctrl;

`ifdef SEGRE_DCACHE_PLRU_EN
  localparam bit PLRU_MODE = 1'b1;
`else
  localparam bit PLRU_MODE = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rsn_i;
  logic         miss_i;
  logic [27:0]  miss_tag_i;
  logic         hit_i;
  logic [2:0]   hit_index_i;
  logic [7:0]   lane_valid_i;
  logic         invalidate_i;
  logic         busy_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [127:0] mem_rdata_i;
  logic         fill_o;
  logic [2:0]   fill_index_o;
  logic [27:0]  fill_tag_o;
  logic [127:0] fill_data_o;

  segre_dcache_refill_ctrl dut (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .miss_i       (miss_i),
    .miss_tag_i   (miss_tag_i),
    .hit_i        (hit_i),
    .hit_index_i  (hit_index_i),
    .lane_valid_i (lane_valid_i),
    .invalidate_i (invalidate_i),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .fill_o       (fill_o),
    .fill_index_o (fill_index_o),
    .fill_tag_o   (fill_tag_o),
    .fill_data_o  (fill_data_o)
  );

  always #5 clk_i = ~clk_i;

  int           n_vec = 0;
  int           n_err = 0;
  bit           hit_en = 1'b0;
  // Reference model state: round-robin pointer and last issued fill.
  int           rr_ptr = 0;
  logic [2:0]   last_idx = '0;
  logic [27:0]  last_tag = '0;
  logic [127:0] last_data = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (hit_en) begin
      hit_i       = 1'($urandom);
      hit_index_i = 3'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_req"}, 128'(mem_req_o), 128'(0));
    chk({tag, "_addr"}, 128'(mem_addr_o), 128'(0));
    chk({tag, "_fill"}, 128'(fill_o), 128'(0));
    chk({tag, "_fidx"}, 128'(fill_index_o), 128'(0));
    chk({tag, "_ftag"}, 128'(fill_tag_o), 128'(0));
    chk({tag, "_fdata"}, fill_data_o, 128'(0));
  endtask

  // inv: 0 none, 1 invalidate first MEM_WAIT cycle, 2 invalidate in MEM_REQ before gnt, 3 with gnt
  task automatic do_refill(input logic [27:0] tag, input logic [7:0] lv, input int gd, input int rd,
                           input int inv, input logic [127:0] data, input bit hold);
    logic [2:0] exp_idx;
    bit         pol;
    bit         dropped;
    pol     = 1'b1;
    exp_idx = 3'(rr_ptr);
    for (int i = 7; i >= 0; i--) begin
      if (!lv[i]) begin
        exp_idx = 3'(i);
        pol     = 1'b0;
      end
    end
    lane_valid_i = lv;
    miss_tag_i   = tag;
    miss_i       = 1'b1;
    chk("idle_busy", 128'(busy_o), 128'(0));
    step();
    if (!hold) miss_i = 1'b0;
    chk("req_rise", 128'(mem_req_o), 128'(1));
    chk("req_addr", 128'(mem_addr_o), 128'({tag, 4'h0}));
    chk("req_busy", 128'(busy_o), 128'(1));
    if (inv == 2) begin
      invalidate_i = 1'b1;
      step();
      invalidate_i = 1'b0;
      miss_i       = 1'b0;
      rr_ptr       = 0;
      chk("cancel_req", 128'(mem_req_o), 128'(0));
      chk("cancel_busy", 128'(busy_o), 128'(0));
      return;
    end
    for (int k = 0; k < gd; k++) begin
      step();
      chk("req_hold", 128'(mem_req_o), 128'(1));
      chk("addr_hold", 128'(mem_addr_o), 128'({tag, 4'h0}));
    end
    mem_gnt_i = 1'b1;
    if (inv == 3) begin
      invalidate_i = 1'b1;
      rr_ptr       = 0;
    end
    step();
    mem_gnt_i    = 1'b0;
    invalidate_i = 1'b0;
    chk("req_drop", 128'(mem_req_o), 128'(0));
    chk("wait_busy", 128'(busy_o), 128'(1));
    for (int k = 1; k <= rd; k++) begin
      if (inv == 1 && k == 1) begin
        invalidate_i = 1'b1;
        rr_ptr       = 0;
      end
      if (k == rd) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
      end
      step();
      invalidate_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (k < rd) begin
        chk("wait_nofill", 128'(fill_o), 128'(0));
        chk("wait_noreq", 128'(mem_req_o), 128'(0));
      end
    end
    dropped = (inv == 1) || (inv == 3);
    if (dropped) begin
      miss_i = 1'b0;
      chk("drop_nofill", 128'(fill_o), 128'(0));
      chk("drop_busy", 128'(busy_o), 128'(0));
      chk("drop_fidx_hold", 128'(fill_index_o), 128'(last_idx));
      chk("drop_fdata_hold", fill_data_o, last_data);
      return;
    end
    miss_i = 1'b0;
    chk("fill_strobe", 128'(fill_o), 128'(1));
    chk("fill_busy", 128'(busy_o), 128'(1));
    if (!(pol && PLRU_MODE)) chk("fill_index", 128'(fill_index_o), 128'(exp_idx));
    chk("fill_tag", 128'(fill_tag_o), 128'(tag));
    chk("fill_data", fill_data_o, data);
    last_idx  = fill_index_o;
    last_tag  = tag;
    last_data = data;
    if (pol) rr_ptr = (rr_ptr + 1) % 8;
    step();
    chk("fill_once", 128'(fill_o), 128'(0));
    chk("idle_after", 128'(busy_o), 128'(0));
    chk("fidx_hold", 128'(fill_index_o), 128'(last_idx));
    chk("ftag_hold", 128'(fill_tag_o), 128'(last_tag));
  endtask

  task automatic apply_reset();
    rsn_i = 1'b0;
    step();
    step();
    @(negedge clk_i);
    rsn_i = 1'b1;
    step();
    rr_ptr    = 0;
    last_idx  = '0;
    last_tag  = '0;
    last_data = '0;
  endtask

  initial begin
    rsn_i        = 1'b0;
    miss_i       = 1'b0;
    miss_tag_i   = '0;
    hit_i        = 1'b0;
    hit_index_i  = '0;
    lane_valid_i = '0;
    invalidate_i = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    step();
    step();
    check_reset_outputs("reset");
    @(negedge clk_i);
    rsn_i = 1'b1;
    step();

    // Empty cache: gnt cycle 2, rvalid cycle 4, fill cycle 5 into lane 0.
    do_refill(28'h000ABC, 8'h00, 1, 2, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
    do_refill(28'h1111111, 8'b1110_1111, 0, 1, 0, 128'hDEAD_BEEF, 1'b0);
    if (!PLRU_MODE) begin
      for (int i = 0; i < 9; i++) begin
        do_refill(28'(32'h0200000 + i), 8'hFF, 0, 1, 0, {4{$urandom()}}, 1'b0);
      end
    end
    do_refill(28'h3333333, 8'hFF, 0, 4, 1, 128'h55, 1'b0);
    do_refill(28'h4444444, 8'h0F, 2, 3, 0, 128'hAAAA_5555, 1'b1);
    do_refill(28'h5555555, 8'hFF, 1, 2, 1, 128'h77, 1'b1);
    do_refill(28'h6666666, 8'h01, 1, 1, 2, 128'h88, 1'b0);
    do_refill(28'h7777777, 8'hFF, 0, 2, 3, 128'h99, 1'b0);
    do_refill(28'h8888888, 8'hFF, 0, 1, 0, 128'hAB, 1'b0);

    // Asynchronous reset in the middle of MEM_WAIT aborts everything.
    lane_valid_i = 8'h00;
    miss_tag_i   = 28'h1234567;
    miss_i       = 1'b1;
    step();
    miss_i    = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    step();
    #2 rsn_i = 1'b0;
    #1 check_reset_outputs("midwait_rst");
    @(negedge clk_i);
    rsn_i = 1'b1;
    step();
    rr_ptr    = 0;
    last_idx  = '0;
    last_tag  = '0;
    last_data = '0;

`ifdef SEGRE_DCACHE_PLRU_EN
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      hit_i       = 1'b1;
      hit_index_i = 3'(2 * i);
      step();
    end
    hit_i = 1'b0;
    do_refill(28'h0FEDCBA, 8'hFF, 0, 1, 0, 128'h1234, 1'b0);
    chk("plru_odd_victim", 128'(last_idx[0]), 128'(1));
`endif

    apply_reset();
    hit_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [7:0]   lv;
      int           mode;
      mode = int'($urandom_range(0, 9));
      lv   = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom());
      do_refill(28'($urandom()), lv, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                (mode < 4) ? mode : 0, {$urandom(), $urandom(), $urandom(), $urandom()},
                1'($urandom()));
      if ($urandom_range(0, 1) == 1) step();
    end
    hit_en = 1'b0;
    hit_i  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
